// File: rtl/cpu_seq.sv
// Check-parity sequencer: streams one pass of N check-memory rows to the output,
// writes each row back after a fixed latency, and reports done with a one-cycle pulse.
module cpu_seq #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rate,
    input  logic        cpu_a,
    input  logic [17:0] par_in,
    output logic        cpu_b,
    output logic        cpu_en_out,
    output logic [17:0] cpu_dout2,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic        cpu_busy
);

    localparam int unsigned DEPTH  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned RD_TAP = RD_LAT - 1;
    localparam int unsigned WR_TAP = WR_LAT - 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic        rate_q;
    logic [7:0]  rd_addr_q;
    logic [7:0]  last_addr;
    logic [DEPTH-1:0] vld_q;
    logic [7:0]  addr_q [DEPTH];
    logic        en_q;
    logic [17:0] dout_q;
    logic        pending;

    assign last_addr = rate_q ? 8'd127 : 8'd255;

    // Rows still owed an output after this cycle: anything not yet at the last
    // stage, plus a row at the read tap whose strobe is registered next cycle.
    always_comb begin
        pending = vld_q[RD_TAP];
        for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
            pending = pending | vld_q[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_en    = 1'b0;
        cpu_b    = 1'b0;
        cpu_busy = (state_q != IDLE);
        unique case (state_q)
            IDLE:  if (cpu_a) state_d = READ;
            READ: begin
                rd_en = 1'b1;
                if (rd_addr_q == last_addr) state_d = DRAIN;
            end
            DRAIN: if (!pending) state_d = DONE;
            DONE: begin
                cpu_b   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rate_q    <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) addr_q[k] <= '0;
            en_q      <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_a) begin
                rate_q    <= rate;
                rd_addr_q <= '0;
            end else if (state_q == READ && rd_addr_q != last_addr) begin
                rd_addr_q <= rd_addr_q + 8'd1;
            end
            vld_q[0]  <= rd_en;
            addr_q[0] <= rd_addr_q;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                vld_q[k]  <= vld_q[k-1];
                addr_q[k] <= addr_q[k-1];
            end
            en_q   <= vld_q[RD_TAP];
            dout_q <= vld_q[RD_TAP] ? par_in : '0;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign cpu_en_out = en_q;
    assign cpu_dout2  = dout_q;
    assign wr_en      = vld_q[WR_TAP];
    assign wr_addr    = vld_q[WR_TAP] ? addr_q[WR_TAP] : '0;

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter RD_LAT, default 2, cycles from rd_en to valid par_in.
REQ-002 Parameter WR_LAT, default 3, cycles from rd_en of a row to its write-back wr_en.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 rate  input  1  code rate: 0 = 1/2 (256 rows), 1 = 3/4 (128 rows).
REQ-006 cpu_a  input  1  one-cycle start pulse from decoder controller.
REQ-007 par_in  input  18  per-lane check parity from check core, valid RD_LAT cycles after rd_en.
REQ-008 cpu_b  output  1  one-cycle done pulse.
REQ-009 cpu_en_out  output  1  cpu_dout2 valid strobe, one per row.
REQ-010 cpu_dout2  output  18  registered per-lane parity of current row.
REQ-011 rd_en  output  1  check-memory read enable.
REQ-012 rd_addr  output  8  check-memory row address.
REQ-013 wr_en  output  1  check-memory write-back enable.
REQ-014 wr_addr  output  8  write-back row address.
REQ-015 cpu_busy  output  1  pass in progress.

Function
REQ-016 rate SHALL be latched on accepted cpu_a; row count N = 256 (rate 0) or 128 (rate 1); rate changes mid-pass ignored.
REQ-017 States SHALL be IDLE, READ, DRAIN, DONE, one-hot encoded.
REQ-018 IDLE: cpu_a -> READ; cpu_a in any other state SHALL be ignored (no restart, no counter change).
REQ-019 READ: rd_en = 1 every cycle; rd_addr starts at 0 on the first READ cycle and increments by 1 per cycle, 8-bit.
REQ-020 READ -> DRAIN in the cycle after rd_addr == N-1 is issued; rd_addr SHALL hold N-1, rd_en = 0 outside READ.
REQ-021 A valid/address delay line SHALL track each issued row; rows are never dropped or reordered.
REQ-022 cpu_en_out SHALL assert RD_LAT+1 cycles after the row's rd_en, with cpu_dout2 = par_in sampled RD_LAT cycles after that rd_en.
REQ-023 cpu_dout2 SHALL be 0 whenever cpu_en_out = 0.
REQ-024 wr_en SHALL assert WR_LAT cycles after the row's rd_en, with wr_addr equal to that row's rd_addr; wr_addr = 0 when wr_en = 0.
REQ-025 DRAIN -> DONE once the delay line is empty, i.e. after the final cpu_en_out and final wr_en have been issued.
REQ-026 DONE: cpu_b = 1 for exactly one cycle, then -> IDLE; a cpu_a in that same DONE cycle SHALL be ignored.
REQ-027 With defaults: cpu_a at cycle 0, rd_en cycles 1..N, last cpu_en_out and wr_en at N+3, cpu_b at N+4.
REQ-028 cpu_busy SHALL be 1 from the cycle after accepted cpu_a through the cpu_b cycle inclusive, else 0.
REQ-029 Exactly N cpu_en_out pulses and N wr_en pulses SHALL occur per pass.
REQ-030 Back-to-back passes: cpu_a in the cycle after cpu_b SHALL be accepted normally.

Reset
REQ-031 reset_n low SHALL force IDLE, clear the delay line and rate latch, and drive every output to 0, independent of clk.
REQ-032 Reset asserted mid-pass SHALL abandon the pass; no cpu_b, cpu_en_out or wr_en SHALL follow the reset release until a new cpu_a.

Verification
REQ-033 rate=0, cpu_a at cycle 0 -> rd_addr 0..255 on cycles 1..256, 256 cpu_en_out, 256 wr_en (last at 259, wr_addr 255), cpu_b at 260.
REQ-034 rate=1, cpu_a -> 128 reads, cpu_b at cycle 132; rate toggled to 0 at cycle 50 -> no effect.
REQ-035 par_in driven with row index pattern {10'b0, row[7:0]} -> each cpu_en_out carries matching cpu_dout2, zero between strobes.
REQ-036 cpu_a pulsed at cycles 40 and 260 (rate 0) -> both ignored, single cpu_b at 260; cpu_a at 261 -> second pass, cpu_b at 521.
REQ-037 reset_n low at cycle 100 of a rate-0 pass for 2 cycles -> all outputs 0 immediately, no cpu_b afterwards; new cpu_a -> full clean pass.
